keypad_scanner: RTL

- Drives and reads the 4x3 matrix keypad (rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#). This is the producer side of the game's keypad interface.
- Scans one column at a time, synchronizes and debounces the row returns, and presents debounced level outputs Keypad[9:0] and KeypadHash.
- Those outputs feed the game top's rising-edge triggers directly. KEY_CODE/KEY_PRESS are added for future menu logic.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/keypad_scanner_if.sv | 14 +
 rtl/keypad_debounce.sv | 51 +++++
 rtl/keypad_scanner.sv | 102 ++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x3 matrix keypad scanner.
// Key position p = row*3 + col, row 0 = 1-2-3, col 0 = left.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  localparam logic [3:0] POS_CODE [NUM_KEYS] = '{
    4'd1, 4'd2, 4'd3,
    4'd4, 4'd5, 4'd6,
    4'd7, 4'd8, 4'd9,
    KEY_STAR, 4'd0, KEY_HASH
  };

endpackage

// File: rtl/keypad_scanner_if.sv
// Debounced keypad outputs as seen by the game top.
// The scanner drives the master side; consumers attach to the slave side.
interface keypad_scanner_if;

  logic [9:0] Keypad;
  logic       KeypadHash;
  logic       KeypadStar;
  logic [3:0] KEY_CODE;
  logic       KEY_PRESS;

  modport master (output Keypad, KeypadHash, KeypadStar, KEY_CODE, KEY_PRESS);
  modport slave  (input  Keypad, KeypadHash, KeypadStar, KEY_CODE, KEY_PRESS);

endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a new frame is committed only after it has been
// seen unchanged for DEBOUNCE_SCANS consecutive frame comparisons.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                frame_valid,
  input  logic [NUM_KEYS-1:0] frame,
  output logic [NUM_KEYS-1:0] debounced,
  output logic                rise
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

  logic [NUM_KEYS-1:0] prev_snapshot;
  logic [3:0]          stable_cnt;
  logic [3:0]          stable_nxt;
  logic                commit;

  always_comb begin
    stable_nxt = 4'd0;
    if (frame == prev_snapshot)
      stable_nxt = (stable_cnt == 4'hF) ? stable_cnt : stable_cnt + 4'd1;
  end

  assign commit = (stable_nxt == DB_TARGET) && (frame != debounced);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_snapshot <= '0;
      stable_cnt    <= 4'd0;
      debounced     <= '0;
      rise          <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (frame_valid) begin
        prev_snapshot <= frame;
        stable_cnt    <= stable_nxt;
        if (commit) begin
          debounced <= frame;
          // Only newly pressed keys pulse; pure releases stay silent.
          rise      <= |(frame & ~debounced);
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: one active-low column at a time, two-flop row
// sync, frame debounce, registered level / lowest-code / press outputs.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 2500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_ROWS-1:0] KEY_ROW,
  output logic [NUM_COLS-1:0] KEY_COL,
  keypad_scanner_if.master    kp
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0]       COL_LAST = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DIV_W-1:0]    div_cnt;
  logic [1:0]          col;
  logic [1:0]          col_nxt;
  logic [NUM_KEYS-1:0] snapshot;
  logic [NUM_KEYS-1:0] frame;
  logic [NUM_KEYS-1:0] debounced;
  logic                sample;
  logic                frame_valid;
  logic                rise;
  logic [3:0]          code_nxt;

  assign sample      = (div_cnt == DIV_LAST);
  assign frame_valid = sample && (col == COL_LAST);
  assign col_nxt     = (col == COL_LAST) ? 2'd0 : col + 2'd1;

  // Frame vector including the column being sampled this cycle.
  always_comb begin
    frame = snapshot;
    if (sample)
      for (int r = 0; r < NUM_ROWS; r++)
        frame[4'(r * NUM_COLS) + {2'b00, col}] = ~row_sync[r];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_meta <= '1;
      row_sync <= '1;
      div_cnt  <= '0;
      col      <= 2'd0;
      KEY_COL  <= 3'b110;
      snapshot <= '0;
    end else begin
      row_meta <= KEY_ROW;
      row_sync <= row_meta;
      if (sample) begin
        div_cnt  <= '0;
        col      <= col_nxt;
        KEY_COL  <= ~(NUM_COLS'(1) << col_nxt);
        snapshot <= frame;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .CLK         (CLK),
    .RST         (RST),
    .frame_valid (frame_valid),
    .frame       (frame),
    .debounced   (debounced),
    .rise        (rise)
  );

  always_comb begin
    code_nxt = KEY_NONE;
    for (int p = 0; p < NUM_KEYS; p++)
      if (debounced[p] && (POS_CODE[p] < code_nxt))
        code_nxt = POS_CODE[p];
  end

  // Digits 1-9 sit at positions 0-8, digit 0 at 10, * at 9, # at 11.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      kp.Keypad     <= '0;
      kp.KeypadHash <= 1'b0;
      kp.KeypadStar <= 1'b0;
      kp.KEY_CODE   <= KEY_NONE;
      kp.KEY_PRESS  <= 1'b0;
    end else begin
      kp.Keypad     <= {debounced[8:0], debounced[10]};
      kp.KeypadHash <= debounced[11];
      kp.KeypadStar <= debounced[9];
      kp.KEY_CODE   <= code_nxt;
      kp.KEY_PRESS  <= rise;
    end
  end

endmodule
